// File: rtl/async_fifo_stream_writer_pkg.sv
// Shared types and helpers for the async FIFO stream writer.
// Holds the serializer state encoding and the word-index width rule.
package async_fifo_stream_writer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } writer_state_t;

    // A single-word beat still needs a 1-bit index so the port widths stay legal.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/async_fifo_stream_writer.sv
// Write-side producer for the async FIFO: takes wide beats on a valid/ready
// stream and strobes them into the FIFO one WIDTH-bit word per write_clk cycle.
//
// state | meaning
// IDLE  | no beat held; in_ready high unless flush
// SEND  | beat held in shift register; words go out while fifo_write_ready
module async_fifo_stream_writer
    import async_fifo_stream_writer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int WORDS       = 4,
    parameter int MSB_FIRST   = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     write_clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*WORDS-1:0]   in_data,
    input  logic                     fifo_write_ready,
    output logic                     fifo_write_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic                     busy,
    output logic [COUNT_WIDTH-1:0]   words_written
);

    localparam int BW = WIDTH * WORDS;
    localparam int IW = idx_width(WORDS);

    writer_state_t    state;
    logic [BW-1:0]    shift_q;
    logic [BW-1:0]    shift_next;
    logic [IW-1:0]    idx;
    logic             last_word;
    logic             beat_accept;

    assign last_word     = (idx == IW'(WORDS - 1));
    assign fifo_write_en = (state == SEND) && fifo_write_ready;
    assign busy          = (state == SEND);
    // Ready on the last word lets the next beat load with no bubble.
    assign in_ready      = !flush && ((state == IDLE) ||
                           ((state == SEND) && last_word && fifo_write_ready));
    assign beat_accept   = in_valid && in_ready;

    generate
        if (WORDS == 1) begin : g_single
            assign shift_next = '0;
            assign fifo_data  = shift_q;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shift_next = {shift_q[BW-WIDTH-1:0], {WIDTH{1'b0}}};
            assign fifo_data  = shift_q[BW-1 -: WIDTH];
        end else begin : g_lsb
            assign shift_next = {{WIDTH{1'b0}}, shift_q[BW-1:WIDTH]};
            assign fifo_data  = shift_q[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            idx           <= '0;
            shift_q       <= '0;
            words_written <= '0;
        end else begin
            // A write in the flush cycle still lands in the FIFO, so count it.
            if (fifo_write_en) begin
                words_written <= words_written + COUNT_WIDTH'(1);
            end

            if (flush) begin
                state <= IDLE;
                idx   <= '0;
            end else if (beat_accept) begin
                state   <= SEND;
                idx     <= '0;
                shift_q <= in_data;
            end else if (fifo_write_en) begin
                shift_q <= shift_next;
                if (last_word) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_stream_writer.sv
// Bench for async_fifo_stream_writer: directed vector table, hand sequences for
// wrap and async reset, then random traffic against a word-queue model.
module tb_async_fifo_stream_writer;

    logic        write_clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        fifo_write_ready;

    logic        in_ready_l, wen_l, busy_l;
    logic [7:0]  data_l;
    logic [3:0]  ww_l;
    logic        in_ready_m, wen_m, busy_m;
    logic [7:0]  data_m;
    logic [15:0] ww_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 write_clk = ~write_clk;

    async_fifo_stream_writer #(.WIDTH(8), .WORDS(4), .MSB_FIRST(0), .COUNT_WIDTH(4)) dut_l (
        .write_clk(write_clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_l), .in_data(in_data), .fifo_write_ready(fifo_write_ready),
        .fifo_write_en(wen_l), .fifo_data(data_l), .busy(busy_l), .words_written(ww_l));

    async_fifo_stream_writer #(.WIDTH(8), .WORDS(4), .MSB_FIRST(1), .COUNT_WIDTH(16)) dut_m (
        .write_clk(write_clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_m), .in_data(in_data), .fifo_write_ready(fifo_write_ready),
        .fifo_write_en(wen_m), .fifo_data(data_m), .busy(busy_m), .words_written(ww_m));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    typedef struct {
        int unsigned v, data, r, f;
        int unsigned wen, dl, dm, ir, busy, ww;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int unsigned v, d, r, f, wen, dl, dm, ir, bz, ww);
        vec_t t;
        t.v = v; t.data = d; t.r = r; t.f = f;
        t.wen = wen; t.dl = dl; t.dm = dm; t.ir = ir; t.busy = bz; t.ww = ww;
        return t;
    endfunction

    logic [7:0]  q_l[$];
    logic [7:0]  q_m[$];
    logic [3:0]  cnt_l;
    logic [15:0] cnt_m;

    initial begin
        int accepts;
        int guard;
        logic exp_busy, exp_wen, exp_ir;

        // single beat, LSB/MSB order
        tbl.push_back(mk(1, 32'hDDCCBBAA, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hBB, 8'hCC, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hCC, 8'hBB, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hDD, 8'hAA, 1, 1, 3));
        // back-to-back beats
        tbl.push_back(mk(1, 32'h04030201, 1, 0, 0, 8'h00, 8'h00, 1, 0, 4));
        tbl.push_back(mk(1, 32'h08070605, 1, 0, 1, 8'h01, 8'h04, 0, 1, 4));
        tbl.push_back(mk(1, 32'h08070605, 1, 0, 1, 8'h02, 8'h03, 0, 1, 5));
        tbl.push_back(mk(1, 32'h08070605, 1, 0, 1, 8'h03, 8'h02, 0, 1, 6));
        tbl.push_back(mk(1, 32'h08070605, 1, 0, 1, 8'h04, 8'h01, 1, 1, 7));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h05, 8'h08, 0, 1, 8));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h06, 8'h07, 0, 1, 9));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h07, 8'h06, 0, 1, 10));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h08, 8'h05, 1, 1, 11));
        // back-pressure with BB pending
        tbl.push_back(mk(1, 32'hDDCCBBAA, 1, 0, 0, 8'h00, 8'h00, 1, 0, 12));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hAA, 8'hDD, 0, 1, 12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hBB, 8'hCC, 0, 1, 13));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hBB, 8'hCC, 0, 1, 13));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hBB, 8'hCC, 0, 1, 13));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hBB, 8'hCC, 0, 1, 13));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hCC, 8'hBB, 0, 1, 14));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hDD, 8'hAA, 1, 1, 15));
        // flush after two words, with FIFO stalled in the flush cycle
        tbl.push_back(mk(1, 32'hDDCCBBAA, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hAA, 8'hDD, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hBB, 8'hCC, 0, 1, 1));
        tbl.push_back(mk(1, 32'hDDCCBBAA, 0, 1, 0, 8'hCC, 8'hBB, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 2));
        // flush coinciding with a transfer: the write is kept and counted
        tbl.push_back(mk(1, 32'h44332211, 1, 0, 0, 8'h00, 8'h00, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h11, 8'h44, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h22, 8'h33, 0, 1, 3));
        // MSB-first reference beat
        tbl.push_back(mk(1, 32'h11223344, 1, 0, 0, 8'h00, 8'h00, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h44, 8'h11, 0, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h33, 8'h22, 0, 1, 5));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h22, 8'h33, 0, 1, 6));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'h11, 8'h44, 1, 1, 7));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8));

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; fifo_write_ready = 1'b1;
        #12;
        chk("rst_wen",      32'(wen_l),      0);
        chk("rst_busy",     32'(busy_l),     0);
        chk("rst_data",     32'(data_l),     0);
        chk("rst_data_m",   32'(data_m),     0);
        chk("rst_ww",       32'(ww_l),       0);
        chk("rst_in_ready", 32'(in_ready_l), 1);
        @(negedge write_clk);
        rstn = 1'b1;
        step();

        foreach (tbl[i]) begin
            in_valid         = (tbl[i].v != 0);
            in_data          = tbl[i].data;
            fifo_write_ready = (tbl[i].r != 0);
            flush            = (tbl[i].f != 0);
            @(negedge write_clk);
            chk($sformatf("vec%0d_wen", i),      32'(wen_l),      tbl[i].wen);
            chk($sformatf("vec%0d_wen_m", i),    32'(wen_m),      tbl[i].wen);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready_l), tbl[i].ir);
            chk($sformatf("vec%0d_busy", i),     32'(busy_l),     tbl[i].busy);
            chk($sformatf("vec%0d_ww", i),       32'(ww_l),       tbl[i].ww);
            if (tbl[i].busy != 0) begin
                chk($sformatf("vec%0d_data", i),   32'(data_l), tbl[i].dl);
                chk($sformatf("vec%0d_data_m", i), 32'(data_m), tbl[i].dm);
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0; fifo_write_ready = 1'b1;

        // counter wrap: 5 beats = 20 words, 4-bit counter shows 4
        rstn = 1'b0; #2; rstn = 1'b1;
        step();
        accepts = 0;
        guard   = 0;
        in_valid = 1'b1;
        while (accepts < 5 && guard < 100) begin
            in_data = $urandom();
            @(negedge write_clk);
            if (in_ready_l) accepts++;
            step();
            if (accepts == 5) in_valid = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (busy_l && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50 || accepts < 5) begin
            n_checks++; n_fail++;
            $display("FAIL wrap_timeout accepts=%0d required=5", accepts);
        end
        @(negedge write_clk);
        chk("wrap_ww",   32'(ww_l), 4);
        chk("wrap_ww_m", 32'(ww_m), 20);
        step();

        // async reset mid-beat
        in_valid = 1'b1; in_data = 32'hDDCCBBAA;
        step();
        in_valid = 1'b0;
        step(); step();
        #2; rstn = 1'b0; #1;
        chk("arst_wen",      32'(wen_l),      0);
        chk("arst_busy",     32'(busy_l),     0);
        chk("arst_data",     32'(data_l),     0);
        chk("arst_data_m",   32'(data_m),     0);
        chk("arst_ww",       32'(ww_l),       0);
        chk("arst_ww_m",     32'(ww_m),       0);
        chk("arst_in_ready", 32'(in_ready_l), 1);
        @(negedge write_clk);
        rstn = 1'b1;
        step();

        // random traffic against a per-beat word queue model
        cnt_l = '0; cnt_m = '0;
        q_l.delete(); q_m.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid         = ($urandom_range(0, 99) < 60);
            in_data          = $urandom();
            fifo_write_ready = ($urandom_range(0, 99) < 70);
            flush            = ($urandom_range(0, 99) < 4);
            @(negedge write_clk);
            exp_busy = (q_l.size() != 0);
            exp_wen  = exp_busy && fifo_write_ready;
            exp_ir   = !flush && (!exp_busy || (q_l.size() == 1 && fifo_write_ready));
            chk("rnd_wen",        32'(wen_l),      32'(exp_wen));
            chk("rnd_wen_m",      32'(wen_m),      32'(exp_wen));
            chk("rnd_busy",       32'(busy_l),     32'(exp_busy));
            chk("rnd_in_ready",   32'(in_ready_l), 32'(exp_ir));
            chk("rnd_in_ready_m", 32'(in_ready_m), 32'(exp_ir));
            chk("rnd_ww",         32'(ww_l),       32'(cnt_l));
            chk("rnd_ww_m",       32'(ww_m),       32'(cnt_m));
            if (exp_busy) begin
                chk("rnd_data",   32'(data_l), 32'(q_l[0]));
                chk("rnd_data_m", 32'(data_m), 32'(q_m[0]));
            end
            if (exp_wen) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
                cnt_l = cnt_l + 4'd1;
                cnt_m = cnt_m + 16'd1;
            end
            if (flush) begin
                q_l.delete();
                q_m.delete();
            end else if (in_valid && exp_ir) begin
                for (int w = 0; w < 4; w++) begin
                    q_l.push_back(in_data[8*w +: 8]);
                    q_m.push_back(in_data[8*(3-w) +: 8]);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
